// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the memory port arbiter.
// Contents:
//   ADDR_WIDTH_DEF - default address bus width
//   WIDTH_*        - mem_width encodings (3 is treated as word)
//   arb_state_e    - arbiter FSM states
//   width_to_bytes - number of byte transfers for a given width code
package cpu_defs_pkg;

    localparam int ADDR_WIDTH_DEF = 32;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        DONE   = 3'd4
    } arb_state_e;

    // Width code 3 is not a legal encoding but is handled as a word.
    function automatic logic [2:0] width_to_bytes(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: return 3'd1;
            WIDTH_HALF: return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Byte counter plus 32-bit assemble register shared by the read and write
// paths of mem_port_arbiter.
// Ports:
//   clk, rst         - clock, asynchronous active-low reset
//   load, load_data  - restart: cnt=0, register=load_data (store data or 0)
//   step             - advance the byte counter
//   cap, din         - write din into byte lane cnt-1 (read capture)
//   cnt              - current byte counter
//   data_next        - register value including this cycle's capture/load
//   next_byte        - byte lane cnt+1 of the register (next store byte)
module byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        step,
    input  logic        cap,
    input  logic [7:0]  din,
    output logic [2:0]  cnt,
    output logic [31:0] data_next,
    output logic [7:0]  next_byte
);

    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] data_q;
    logic [2:0]  cap_sub;
    logic [1:0]  cap_idx;
    logic [2:0]  nxt_sub;
    logic [1:0]  nxt_idx;

    // A read byte arrives one cycle after its address, so the byte
    // captured while the counter reads k belongs to lane k-1.
    assign cap_sub = cnt_q - 3'd1;
    assign cap_idx = cap_sub[1:0];
    assign nxt_sub = cnt_q + 3'd1;
    assign nxt_idx = nxt_sub[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign data_next[8*gi +: 8] =
                load                           ? load_data[8*gi +: 8] :
                (cap && (cap_idx == 2'(gi)))   ? din                  :
                                                 data_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = 3'd0;
        end else if (step) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= 3'd0;
            data_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_next;
        end
    end

    assign cnt       = cnt_q;
    assign next_byte = data_q[8*nxt_idx +: 8];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and the MEM-stage
// load/store unit, serialising 8/16/32-bit accesses into byte transfers.
// Ports:
//   clk, rst (async active-low), jump_flag_in (aborts an in-flight fetch)
//   if_req/if_addr -> if_data/if_done          : 4-byte fetches
//   mem_req/mem_we/mem_width/mem_addr/mem_wdata -> mem_rdata/mem_done
//   busy_line                                   : pipeline stall request
//   ram_addr/ram_wr/ram_dout/ram_din            : byte RAM, 1-cycle read
// Build option: define MEM_PORT_ARBITER_RR_EN for round-robin arbitration
// when both requests are pending; default is fixed MEM-over-IF priority.
module mem_port_arbiter
    import cpu_defs_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int RAM_RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump_flag_in,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [31:0]           if_data,
    output logic                  if_done,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [1:0]            mem_width,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic [31:0]           mem_rdata,
    output logic                  mem_done,
    output logic                  busy_line,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din
);

    generate
        if (RAM_RD_LAT != 1) begin : g_bad_rd_lat
            $error("mem_port_arbiter: only RAM_RD_LAT=1 is supported");
        end
    endgenerate

    arb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [2:0]            nbytes_q, nbytes_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  ram_wr_q, ram_wr_d;
    logic [7:0]            ram_dout_q, ram_dout_d;
    logic [31:0]           if_data_q, if_data_d;
    logic [31:0]           mem_rdata_q, mem_rdata_d;
    logic                  if_done_q, if_done_d;
    logic                  mem_done_q, mem_done_d;

    logic                  asm_load, asm_step, asm_cap;
    logic [31:0]           asm_load_data;
    logic [2:0]            asm_cnt, cnt_nxt;
    logic [31:0]           asm_data_next;
    logic [7:0]            asm_next_byte;

    logic                  prefer_if, grant_mem, grant_if;

`ifdef MEM_PORT_ARBITER_RR_EN
    // Class of the last completed access; aborted fetches do not count.
    logic last_mem_q, last_mem_d;
    assign prefer_if = last_mem_q;
`else
    assign prefer_if = 1'b0;
`endif

    assign grant_mem = mem_req & ~(if_req & prefer_if);
    assign grant_if  = if_req & ~grant_mem;
    assign cnt_nxt   = asm_cnt + 3'd1;

    byte_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .load      (asm_load),
        .load_data (asm_load_data),
        .step      (asm_step),
        .cap       (asm_cap),
        .din       (ram_din),
        .cnt       (asm_cnt),
        .data_next (asm_data_next),
        .next_byte (asm_next_byte)
    );

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        nbytes_d      = nbytes_q;
        ram_addr_d    = ram_addr_q;
        ram_wr_d      = 1'b0;
        ram_dout_d    = ram_dout_q;
        if_data_d     = if_data_q;
        mem_rdata_d   = mem_rdata_q;
        if_done_d     = 1'b0;
        mem_done_d    = 1'b0;
        asm_load      = 1'b0;
        asm_load_data = 32'd0;
        asm_step      = 1'b0;
        asm_cap       = 1'b0;
`ifdef MEM_PORT_ARBITER_RR_EN
        last_mem_d    = last_mem_q;
`endif
        case (state_q)
            IDLE: begin
                // Byte 0 address (and store byte) is registered on the
                // accept edge so the RAM sees it in the first busy cycle.
                if (grant_mem) begin
                    base_d     = mem_addr;
                    nbytes_d   = width_to_bytes(mem_width);
                    ram_addr_d = mem_addr;
                    asm_load   = 1'b1;
                    if (mem_we) begin
                        state_d       = MEM_WR;
                        ram_wr_d      = 1'b1;
                        ram_dout_d    = mem_wdata[7:0];
                        asm_load_data = mem_wdata;
                    end else begin
                        state_d = MEM_RD;
                    end
                end else if (grant_if) begin
                    base_d     = if_addr;
                    nbytes_d   = 3'd4;
                    ram_addr_d = if_addr;
                    asm_load   = 1'b1;
                    state_d    = IF_RD;
                end
            end
            IF_RD, MEM_RD: begin
                if ((state_q == IF_RD) && jump_flag_in) begin
                    state_d = IDLE;
                end else begin
                    // Counter k: capture byte k-1 while issuing address k.
                    asm_step = 1'b1;
                    asm_cap  = (asm_cnt != 3'd0);
                    if (asm_cnt == nbytes_q) begin
                        state_d = DONE;
                        if (state_q == IF_RD) begin
                            if_data_d = asm_data_next;
                            if_done_d = 1'b1;
`ifdef MEM_PORT_ARBITER_RR_EN
                            last_mem_d = 1'b0;
`endif
                        end else begin
                            mem_rdata_d = asm_data_next;
                            mem_done_d  = 1'b1;
`ifdef MEM_PORT_ARBITER_RR_EN
                            last_mem_d = 1'b1;
`endif
                        end
                    end else if (cnt_nxt < nbytes_q) begin
                        ram_addr_d = base_q + ADDR_WIDTH'(cnt_nxt);
                    end
                end
            end
            MEM_WR: begin
                asm_step = 1'b1;
                if (cnt_nxt == nbytes_q) begin
                    state_d    = DONE;
                    mem_done_d = 1'b1;
`ifdef MEM_PORT_ARBITER_RR_EN
                    last_mem_d = 1'b1;
`endif
                end else begin
                    ram_wr_d   = 1'b1;
                    ram_addr_d = base_q + ADDR_WIDTH'(cnt_nxt);
                    ram_dout_d = asm_next_byte;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            nbytes_q    <= 3'd0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'd0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
`ifdef MEM_PORT_ARBITER_RR_EN
            last_mem_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            nbytes_q    <= nbytes_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
`ifdef MEM_PORT_ARBITER_RR_EN
            last_mem_q  <= last_mem_d;
`endif
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wr    = ram_wr_q;
    assign ram_dout  = ram_dout_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;
    // A flush arriving in the DONE cycle of a fetch kills the pulse.
    assign if_done   = if_done_q & ~jump_flag_in;
    assign mem_done  = mem_done_q;
    // Stall in IDLE as soon as a request shows up so the requesting stage
    // holds; released in DONE so the pipeline advances on the done edge.
    assign busy_line = rst & (((state_q != IDLE) && (state_q != DONE)) ||
                              ((state_q == IDLE) && (if_req || mem_req)));

endmodule
